// File: rtl/seg7_scan_mux.sv
// Time-multiplexed common-anode 7-segment driver with frame-coherent capture,
// leading-zero blanking, hex/BCD glyphs and PWM brightness.
module seg7_scan_mux #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 1024,
    parameter int BRIGHT_W    = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  hex_mode,
    input  logic                  lz_blank,
    input  logic [BRIGHT_W-1:0]   brightness,
    input  logic                  enable,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int TW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [TW-1:0]         tick;
    logic [IW-1:0]         idx;

    logic [4*DIGITS-1:0]   sh_value;
    logic [DIGITS-1:0]     sh_dp;
    logic                  sh_hex;
    logic                  sh_lz;
    logic [BRIGHT_W-1:0]   sh_bright;

    logic                  frame_start;
    logic                  tick_last;
    logic                  idx_last;

    logic [4*DIGITS-1:0]   cur_value;
    logic [DIGITS-1:0]     cur_dp;
    logic                  cur_hex;
    logic                  cur_lz;
    logic [BRIGHT_W-1:0]   cur_bright;

    logic [DIGITS-1:0]     blank;
    logic                  seen;
    logic [3:0]            cur_nib;
    logic                  cur_dp_bit;
    logic                  cur_blank;
    logic [DIGITS-1:0]     an_sel;
    logic                  pwm_on;

    function automatic logic [6:0] glyph(input logic [3:0] n, input logic hex);
        logic [6:0] g;
        case (n)
            4'h0:    g = 7'b0000001;
            4'h1:    g = 7'b1001111;
            4'h2:    g = 7'b0010010;
            4'h3:    g = 7'b0000110;
            4'h4:    g = 7'b1001100;
            4'h5:    g = 7'b0100100;
            4'h6:    g = 7'b0100000;
            4'h7:    g = 7'b0001111;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0000100;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b1100000;
            4'hC:    g = 7'b0110001;
            4'hD:    g = 7'b1000010;
            4'hE:    g = 7'b0110000;
            default: g = 7'b0111000;
        endcase
        if (!hex && n > 4'd9) g = 7'b1111111;
        return g;
    endfunction

    assign frame_start = (tick == '0) && (idx == '0);
    assign tick_last   = (tick == TW'(REFRESH_DIV - 1));
    assign idx_last    = (idx == IW'(DIGITS - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            tick <= '0;
            idx  <= '0;
        end else if (tick_last) begin
            tick <= '0;
            idx  <= idx_last ? '0 : idx + 1'b1;
        end else begin
            tick <= tick + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sh_value  <= '0;
            sh_dp     <= '0;
            sh_hex    <= 1'b0;
            sh_lz     <= 1'b0;
            sh_bright <= '0;
        end else if (frame_start) begin
            sh_value  <= value;
            sh_dp     <= dp_in;
            sh_hex    <= hex_mode;
            sh_lz     <= lz_blank;
            sh_bright <= brightness;
        end
    end

    // Slot 0 output is computed on the capture edge, so bypass the shadows then.
    always_comb begin
        cur_value  = frame_start ? value      : sh_value;
        cur_dp     = frame_start ? dp_in      : sh_dp;
        cur_hex    = frame_start ? hex_mode   : sh_hex;
        cur_lz     = frame_start ? lz_blank   : sh_lz;
        cur_bright = frame_start ? brightness : sh_bright;
    end

    always_comb begin
        blank = '0;
        seen  = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (cur_value[4*i +: 4] != 4'h0 || cur_dp[i]) seen = 1'b1;
            blank[i] = cur_lz && !seen;
        end
    end

    always_comb begin
        cur_nib    = 4'h0;
        cur_dp_bit = 1'b0;
        cur_blank  = 1'b0;
        an_sel     = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_nib    = cur_value[4*i +: 4];
                cur_dp_bit = cur_dp[i];
                cur_blank  = blank[i];
                an_sel[i]  = 1'b0;
            end
        end
    end

    assign pwm_on = (tick[BRIGHT_W-1:0] < cur_bright) || (&cur_bright);

    always_ff @(posedge clock) begin
        if (reset) begin
            seg        <= 7'b1111111;
            dp         <= 1'b1;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= tick_last && idx_last;
            if (enable && !cur_blank) begin
                seg <= glyph(cur_nib, cur_hex);
                dp  <= ~cur_dp_bit;
                an  <= pwm_on ? an_sel : '1;
            end else begin
                seg <= 7'b1111111;
                dp  <= 1'b1;
                an  <= '1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboard bench for seg7_scan_mux: frame-position reference model pushes
// expected pin state every edge, a negedge monitor pops and compares.
module tb_seg7_scan_mux;

    localparam int ND    = 4;
    localparam int RD    = 16;
    localparam int BW    = 2;
    localparam int FRAME = ND * RD;

    logic            clock;
    logic            reset;
    logic [4*ND-1:0] value;
    logic [ND-1:0]   dp_in;
    logic            hex_mode;
    logic            lz_blank;
    logic [BW-1:0]   brightness;
    logic            enable;
    logic [6:0]      seg;
    logic            dp;
    logic [ND-1:0]   an;
    logic            frame_done;

    seg7_scan_mux #(
        .DIGITS(ND),
        .REFRESH_DIV(RD),
        .BRIGHT_W(BW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .value(value),
        .dp_in(dp_in),
        .hex_mode(hex_mode),
        .lz_blank(lz_blank),
        .brightness(brightness),
        .enable(enable),
        .seg(seg),
        .dp(dp),
        .an(an),
        .frame_done(frame_done)
    );

    typedef struct packed {
        logic [6:0]    seg;
        logic          dp;
        logic [ND-1:0] an;
        logic          fd;
    } obs_t;

    localparam logic [6:0] GLY [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    obs_t q[$];
    int   checks = 0;
    int   errors = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int              cyc;
    logic [4*ND-1:0] m_val;
    logic [ND-1:0]   m_dp;
    logic            m_hex;
    logic            m_lz;
    logic [BW-1:0]   m_br;

    always @(posedge clock) begin
        obs_t e;
        int p, slot, t, top;
        logic [3:0] nib;
        e = '{seg: 7'h7f, dp: 1'b1, an: '1, fd: 1'b0};
        if (reset) begin
            cyc = 0;
        end else begin
            p = cyc % FRAME;
            if (p == 0) begin
                m_val = value;
                m_dp  = dp_in;
                m_hex = hex_mode;
                m_lz  = lz_blank;
                m_br  = brightness;
            end
            slot = p / RD;
            t    = p % RD;
            top  = 0;
            for (int i = 0; i < ND; i++)
                if (m_val[4*i +: 4] != 4'h0 || m_dp[i]) top = i;
            nib  = m_val[4*slot +: 4];
            e.fd = (p == FRAME - 1);
            if (enable && !(m_lz && slot > top)) begin
                e.seg = (nib > 4'd9 && !m_hex) ? 7'h7f : GLY[nib];
                e.dp  = ~m_dp[slot];
                if ((t % (1 << BW)) < int'(m_br) || int'(m_br) == (1 << BW) - 1)
                    e.an = ~ND'(1 << slot);
            end
            cyc++;
        end
        q.push_back(e);
    end

    always @(negedge clock) begin
        obs_t e, a;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = '{seg: seg, dp: dp, an: an, fd: frame_done};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL pins t=%0t: seg=%b dp=%b an=%b fd=%b, want seg=%b dp=%b an=%b fd=%b",
                         $time, a.seg, a.dp, a.an, a.fd, e.seg, e.dp, e.an, e.fd);
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check_reset_state();
        checks++;
        if (an !== '1 || seg !== 7'h7f || dp !== 1'b1 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset t=%0t: an=%b seg=%b dp=%b fd=%b",
                     $time, an, seg, dp, frame_done);
        end
    endtask

    task automatic wait_fd(input int limit, input int want);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (frame_done !== 1'b1 && n < limit);
        checks++;
        if (frame_done !== 1'b1 || n != want) begin
            errors++;
            $display("FAIL wait t=%0t: frame_done after %0d cycles, want %0d",
                     $time, n, want);
        end
    endtask

    initial begin
        reset      = 1'b1;
        value      = 16'h1234;
        dp_in      = '0;
        hex_mode   = 1'b0;
        lz_blank   = 1'b0;
        brightness = 2'd3;
        enable     = 1'b1;
        run(3);
        reset = 1'b0;
        run(2 * FRAME);

        value    = 16'h0050;
        lz_blank = 1'b1;
        run(2 * FRAME);
        dp_in = 4'b0100;
        run(2 * FRAME);

        dp_in    = '0;
        lz_blank = 1'b0;
        value    = 16'hABCF;
        hex_mode = 1'b1;
        run(2 * FRAME);
        hex_mode = 1'b0;
        run(2 * FRAME);

        value      = 16'h1234;
        brightness = 2'd1;
        run(2 * FRAME);
        brightness = 2'd0;
        run(2 * FRAME);
        brightness = 2'd3;
        run(2 * FRAME);

        value = 16'h1111;
        run(FRAME + 2 * RD + 3);
        value = 16'h2222;
        run(2 * FRAME);

        run(3 * RD + 5);
        reset = 1'b1;
        run(1);
        check_reset_state();
        reset = 1'b0;
        wait_fd(FRAME + 4, FRAME);
        run(10);
        enable = 1'b0;
        run(2 * FRAME);
        enable = 1'b1;

        repeat (40) begin
            value      = 16'($urandom);
            dp_in      = ND'($urandom);
            hex_mode   = 1'($urandom);
            lz_blank   = 1'($urandom);
            brightness = BW'($urandom);
            enable     = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) value[15:8] = 8'h00;
            reset = ($urandom_range(0, 19) == 0);
            run(reset ? 1 : $urandom_range(1, 150));
            reset = 1'b0;
        end

        run(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
